// File: rtl/rev_gate_runner_if.sv
// Program/run bus for rev_gate_runner: program-RAM writes, run control and result.
// The master side is the host that loads gates and starts runs.
interface rev_gate_runner_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int IW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic                prog_we;
  logic [AW-1:0]       prog_addr;
  logic [2+3*IW-1:0]   prog_data;
  logic                start;
  logic                dir;
  logic [LW-1:0]       prog_len;
  logic [WIDTH-1:0]    data_in;
  logic                busy;
  logic                done;
  logic [WIDTH-1:0]    data_out;
  logic                err;

  modport master (
    output prog_we, prog_addr, prog_data, start, dir, prog_len, data_in,
    input  busy, done, data_out, err
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, dir, prog_len, data_in,
    output busy, done, data_out, err
  );
endinterface

// File: rtl/rev_gate_runner.sv
// Applies a stored program of reversible gates to a register, one gate per clock,
// forward or reverse. Define REV_FREDKIN_EN to enable op 11 (Fredkin); otherwise op 11 is invalid.
module rev_gate_runner #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  rev_gate_runner_if.slave bus
);
  localparam int IW  = $clog2(WIDTH);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH + 1);
  localparam int PDW = 2 + 3 * IW;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [PDW-1:0]   r_prog [DEPTH];
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_dataOut;
  logic [AW-1:0]    r_ptr;
  logic [LW-1:0]    r_left;
  logic             r_dir;
  logic             r_err;

  logic [PDW-1:0]   w_gate;
  logic [1:0]       w_op;
  logic [IW-1:0]    w_a;
  logic [IW-1:0]    w_b;
  logic [IW-1:0]    w_t;
  logic             w_aOk;
  logic             w_bOk;
  logic             w_tOk;
  logic [WIDTH-1:0] w_next;
  logic             w_gateErr;
  logic             w_lenOver;
  logic [LW-1:0]    w_len;
  logic             w_lastGate;

  // Program RAM is deliberately not reset; it only accepts writes while idle.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && bus.prog_we) begin
      r_prog[bus.prog_addr] <= bus.prog_data;
    end
  end

  assign w_gate     = r_prog[r_ptr];
  assign w_op       = w_gate[PDW-1 -: 2];
  assign w_a        = w_gate[3*IW-1 -: IW];
  assign w_b        = w_gate[2*IW-1 -: IW];
  assign w_t        = w_gate[IW-1:0];
  assign w_aOk      = (32'(w_a) < WIDTH);
  assign w_bOk      = (32'(w_b) < WIDTH);
  assign w_tOk      = (32'(w_t) < WIDTH);
  assign w_lenOver  = (32'(bus.prog_len) > DEPTH);
  assign w_len      = w_lenOver ? LW'(DEPTH) : bus.prog_len;
  assign w_lastGate = (r_left == LW'(1));

  // One gate evaluated against the working register; invalid gates pass it through unchanged.
  always_comb begin
    w_next    = r_work;
    w_gateErr = 1'b0;
    case (w_op)
      2'b00: begin
        if (!w_tOk) w_gateErr = 1'b1;
        else        w_next[w_t] = ~r_work[w_t];
      end
      2'b01: begin
        if (!w_aOk || !w_tOk || w_a == w_t) w_gateErr = 1'b1;
        else                                w_next[w_t] = r_work[w_t] ^ r_work[w_a];
      end
      2'b10: begin
        if (!w_aOk || !w_bOk || !w_tOk || w_a == w_b || w_a == w_t || w_b == w_t)
          w_gateErr = 1'b1;
        else
          w_next[w_t] = r_work[w_t] ^ (r_work[w_a] & r_work[w_b]);
      end
      default: begin
`ifdef REV_FREDKIN_EN
        if (!w_aOk || !w_bOk || !w_tOk || w_a == w_b || w_a == w_t || w_b == w_t) begin
          w_gateErr = 1'b1;
        end else if (r_work[w_a]) begin
          w_next[w_b] = r_work[w_t];
          w_next[w_t] = r_work[w_b];
        end
`else
        w_gateErr = 1'b1;
`endif
      end
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_stateNext = (w_len == '0) ? DONE : RUN;
      RUN:     if (w_lastGate) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Reverse runs start at the last slot; the pointer is frozen on the final gate so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_work    <= '0;
      r_dataOut <= '0;
      r_ptr     <= '0;
      r_left    <= '0;
      r_dir     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_err  <= w_lenOver;
            r_dir  <= bus.dir;
            r_work <= bus.data_in;
            r_left <= w_len;
            r_ptr  <= bus.dir ? AW'(w_len - LW'(1)) : '0;
            if (w_len == '0) r_dataOut <= bus.data_in;
          end
        end
        RUN: begin
          r_work <= w_next;
          r_left <= r_left - LW'(1);
          if (w_gateErr) r_err <= 1'b1;
          if (w_lastGate) r_dataOut <= w_next;
          else            r_ptr <= r_dir ? r_ptr - AW'(1) : r_ptr + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state == RUN);
  assign bus.done     = (r_state == DONE);
  assign bus.data_out = r_dataOut;
  assign bus.err      = r_err;
endmodule

// File: tb/tb_rev_gate_runner.sv
// Scoreboard bench for rev_gate_runner: runs push expected results, a monitor checks each done.
// Expectations for op 11 follow REV_FREDKIN_EN.
module tb_rev_gate_runner;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [7:0] sbData[$];
  logic       sbErr[$];

  rev_gate_runner_if #(.WIDTH(8), .DEPTH(16)) bus ();

  rev_gate_runner #(.WIDTH(8), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Every done is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sbData.size() == 0) begin
        checkOutput("unexpected done", 32'd1, 32'd0);
      end else begin
        checkOutput("data_out", 32'(bus.data_out), 32'(sbData.pop_front()));
        checkOutput("err", 32'(bus.err), 32'(sbErr.pop_front()));
      end
    end
  end

  task automatic writeSlot(input int addr, input int op, input int a, input int b, input int t);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr[3:0];
    bus.prog_data = {op[1:0], a[2:0], b[2:0], t[2:0]};
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input logic dirIn, input logic [4:0] len,
                               input logic [7:0] din, input logic [7:0] expData, input logic expErr,
                               input int expLat, input int expBusy, input bit pokeBusy);
    int lat;
    int busyCnt;
    bit seen;
    sbData.push_back(expData);
    sbErr.push_back(expErr);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dir      = dirIn;
    bus.prog_len = len;
    bus.data_in  = din;
    @(negedge clk);
    bus.start = 1'b0;
    lat       = 1;
    busyCnt   = 0;
    seen      = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) busyCnt++;
        if (pokeBusy && busyCnt == 3) begin
          bus.start     = 1'b1;
          bus.prog_len  = 5'd0;
          bus.data_in   = 8'h12;
          bus.dir       = ~dirIn;
          bus.prog_we   = 1'b1;
          bus.prog_addr = 4'd0;
          bus.prog_data = {2'd1, 3'd3, 3'd0, 3'd3};
        end else begin
          bus.start   = 1'b0;
          bus.prog_we = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    if (!seen) begin
      checkOutput({name, " done timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
      checkOutput({name, " busy cycles"}, 32'(busyCnt), 32'(expBusy));
      @(negedge clk);
      checkOutput({name, " done pulse width"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global timeout actual=running required=finished");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.start     = 1'b0;
    bus.dir       = 1'b0;
    bus.prog_len  = '0;
    bus.data_in   = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset data_out", 32'(bus.data_out), 32'd0);
    checkOutput("reset err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;

    // Toffoli(0,1 -> 2) on 0x03 sets bit 2.
    writeSlot(0, 2, 0, 1, 2);
    applyStimulus("toffoli", 1'b0, 5'd1, 8'h03, 8'h07, 1'b0, 2, 1, 1'b0);

    // NOT(7), CNOT(0->4), Toffoli(1,2->5), CNOT(5->3): 0xA5 -> 0x25 -> 0x35 -> 0x35 -> 0x3D.
    writeSlot(0, 0, 0, 0, 7);
    writeSlot(1, 1, 0, 0, 4);
    writeSlot(2, 2, 1, 2, 5);
    writeSlot(3, 1, 5, 0, 3);
    applyStimulus("prog4 fwd", 1'b0, 5'd4, 8'hA5, 8'h3D, 1'b0, 5, 4, 1'b0);
    applyStimulus("prog4 rev", 1'b1, 5'd4, 8'h3D, 8'hA5, 1'b0, 5, 4, 1'b0);

    applyStimulus("len0", 1'b0, 5'd0, 8'h5A, 8'h5A, 1'b0, 1, 0, 1'b0);

    // CNOT with a == t is an index collision.
    writeSlot(0, 1, 3, 0, 3);
    applyStimulus("collide", 1'b0, 5'd1, 8'h0F, 8'h0F, 1'b1, 2, 1, 1'b0);
    checkOutput("err sticky in idle", 32'(bus.err), 32'd1);
    writeSlot(0, 2, 0, 1, 2);
    applyStimulus("err clears", 1'b0, 5'd1, 8'h03, 8'h07, 1'b0, 2, 1, 1'b0);

    writeSlot(0, 3, 0, 1, 2);
`ifdef REV_FREDKIN_EN
    applyStimulus("fredkin", 1'b0, 5'd1, 8'h03, 8'h05, 1'b0, 2, 1, 1'b0);
`else
    applyStimulus("fredkin off", 1'b0, 5'd1, 8'h03, 8'h03, 1'b1, 2, 1, 1'b0);
`endif

    // Slot i holds NOT(i mod 8) for all 16 slots.
    for (int i = 0; i < 16; i++) writeSlot(i, 0, 0, 0, i % 8);
    applyStimulus("len8 poke", 1'b0, 5'd8, 8'h00, 8'hFF, 1'b0, 9, 8, 1'b1);
    // Length 17 clamps to 16: every bit toggles twice.
    applyStimulus("clamp", 1'b0, 5'd17, 8'h00, 8'h00, 1'b1, 17, 16, 1'b0);
    applyStimulus("len8 rev", 1'b1, 5'd8, 8'h0F, 8'hF0, 1'b0, 9, 8, 1'b0);

    // Abort a run with reset on its third busy cycle.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dir      = 1'b0;
    bus.prog_len = 5'd8;
    bus.data_in  = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort data_out", 32'(bus.data_out), 32'd0);
    checkOutput("abort done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("no done after abort", 32'(bus.done), 32'd0);
    end
    applyStimulus("after abort", 1'b0, 5'd8, 8'h00, 8'hFF, 1'b0, 9, 8, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 32'(sbData.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
